// File: rtl/div16by8_seq.sv
// Sequential restoring divider: 2*DW-bit unsigned dividend by DW-bit divisor,
// one quotient bit per clock, valid/ready handshake on both sides.
module div16by8_seq #(
    parameter int DW = 8,
    parameter int CW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*DW-1:0] dividend,
    input  logic [DW-1:0]   divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   quotient,
    output logic [DW-1:0]   remainder,
    output logic            div_zero,
    output logic            overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    // The partial remainder always stays below the divisor, so DW bits hold it.
    logic [DW-1:0]   rem_reg, rem_next;
    // Low dividend half shifts out of the top while quotient bits enter the bottom.
    logic [DW-1:0]   shift_reg, shift_next;
    logic [DW-1:0]   divisor_reg, divisor_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [DW-1:0]   quotient_reg, quotient_next;
    logic [DW-1:0]   remainder_reg, remainder_next;
    logic            div_zero_reg, div_zero_next;
    logic            overflow_reg, overflow_next;

    logic [DW:0]     trial;
    logic            trial_ge;
    logic [DW-1:0]   trial_diff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            rem_reg       <= '0;
            shift_reg     <= '0;
            divisor_reg   <= '0;
            cnt_reg       <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            div_zero_reg  <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rem_reg       <= rem_next;
            shift_reg     <= shift_next;
            divisor_reg   <= divisor_next;
            cnt_reg       <= cnt_next;
            quotient_reg  <= quotient_next;
            remainder_reg <= remainder_next;
            div_zero_reg  <= div_zero_next;
            overflow_reg  <= overflow_next;
        end
    end

    // Trial subtraction; the difference is below 2^DW whenever it is used.
    assign trial      = {rem_reg, shift_reg[DW-1]};
    assign trial_ge   = (trial >= {1'b0, divisor_reg});
    assign trial_diff = trial[DW-1:0] - divisor_reg;

    always_comb begin
        state_next     = state_reg;
        rem_next       = rem_reg;
        shift_next     = shift_reg;
        divisor_next   = divisor_reg;
        cnt_next       = cnt_reg;
        quotient_next  = quotient_reg;
        remainder_next = remainder_reg;
        div_zero_next  = div_zero_reg;
        overflow_next  = overflow_reg;

        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    divisor_next = divisor;
                    if (divisor == '0) begin
                        state_next     = DONE;
                        quotient_next  = '1;
                        remainder_next = '0;
                        div_zero_next  = 1'b1;
                        overflow_next  = 1'b0;
                    end else if (dividend[2*DW-1:DW] >= divisor) begin
                        state_next     = DONE;
                        quotient_next  = '1;
                        remainder_next = '0;
                        div_zero_next  = 1'b0;
                        overflow_next  = 1'b1;
                    end else begin
                        state_next    = CALC;
                        rem_next      = dividend[2*DW-1:DW];
                        shift_next    = dividend[DW-1:0];
                        cnt_next      = '0;
                        div_zero_next = 1'b0;
                        overflow_next = 1'b0;
                    end
                end
            end
            CALC: begin
                rem_next   = trial_ge ? trial_diff : trial[DW-1:0];
                shift_next = {shift_reg[DW-2:0], trial_ge};
                cnt_next   = cnt_reg + 1'b1;
                if (cnt_reg == CW'(DW - 1)) begin
                    state_next     = DONE;
                    quotient_next  = shift_next;
                    remainder_next = rem_next;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign quotient  = quotient_reg;
    assign remainder = remainder_reg;
    assign div_zero  = div_zero_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_div16by8_seq.sv
// Directed bench for div16by8_seq: handshake timing, error paths, backpressure,
// mid-calculation reset and a short randomized sweep against a reference model.
module tb_div16by8_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        div_zero;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;

    div16by8_seq #(.DW(8), .CW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One division: accept, wait for result, check latency and values,
    // optionally hold backpressure, then take the result.
    task automatic run_div(input logic [15:0] a, input logic [7:0] b,
                           input logic [7:0] exp_q, input logic [7:0] exp_r,
                           input logic exp_dz, input logic exp_ov,
                           input int exp_lat, input int hold);
        int lat;
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        in_valid = 1'b0;
        dividend = 16'hxxxx;
        divisor  = 8'hxx;
        lat = 0;
        while (!out_valid && lat < 40) begin
            check("in_ready_low_busy", 32'(in_ready), 32'd0);
            tick();
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        for (int i = 0; i <= hold; i++) begin
            check("out_valid_held", 32'(out_valid), 32'd1);
            check("quotient", 32'(quotient), 32'(exp_q));
            check("remainder", 32'(remainder), 32'(exp_r));
            check("div_zero", 32'(div_zero), 32'(exp_dz));
            check("overflow", 32'(overflow), 32'(exp_ov));
            if (i < hold) tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("out_valid_after_take", 32'(out_valid), 32'd0);
        check("in_ready_after_take", 32'(in_ready), 32'd1);
        check("quotient_kept", 32'(quotient), 32'(exp_q));
        $display("div 0x%04h / 0x%02h -> q=0x%02h r=0x%02h dz=%0d ov=%0d lat=%0d",
                 a, b, quotient, remainder, div_zero, overflow, lat);
    endtask

    initial begin
        logic [15:0] ra;
        logic [7:0]  rb;
        logic [7:0]  mq;
        logic [7:0]  mr;
        logic        mdz;
        logic        mov;
        int          seen;

        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #2 rst = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_flags", 32'({div_zero, overflow}), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        run_div(16'h1234, 8'h56, 8'h36, 8'h10, 1'b0, 1'b0, 8, 0);
        run_div(16'hFE01, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 8, 0);
        run_div(16'h0010, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b0, 0, 0);
        run_div(16'h5000, 8'h50, 8'hFF, 8'h00, 1'b0, 1'b1, 0, 0);
        run_div(16'hFFFF, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b1, 0, 0);
        run_div(16'h00FF, 8'h10, 8'h0F, 8'h0F, 1'b0, 1'b0, 8, 0);
        run_div(16'h7FFF, 8'h80, 8'hFF, 8'h7F, 1'b0, 1'b0, 8, 0);
        run_div(16'h00C8, 8'h07, 8'h1C, 8'h04, 1'b0, 1'b0, 8, 5);

        // Reset in the middle of a calculation discards the result.
        in_valid = 1'b1;
        dividend = 16'h1234;
        divisor  = 8'h56;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        #2 rst = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_quotient", 32'(quotient), 32'd0);
        check("midrst_remainder", 32'(remainder), 32'd0);
        tick();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("midrst_no_out_valid", 32'(seen), 32'd0);
        $display("reset mid-CALC: out_valid pulses after reset = %0d", seen);
        run_div(16'h0100, 8'h02, 8'h80, 8'h00, 1'b0, 1'b0, 8, 0);

        // Short randomized sweep against an arithmetic reference.
        for (int k = 0; k < 200; k++) begin
            ra = 16'($urandom);
            rb = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
            if (k % 3 == 0) ra[15:8] = 8'($urandom_range(0, 32'(rb)));
            if (rb == 8'h00) begin
                mq = 8'hFF; mr = 8'h00; mdz = 1'b1; mov = 1'b0;
            end else if (ra[15:8] >= rb) begin
                mq = 8'hFF; mr = 8'h00; mdz = 1'b0; mov = 1'b1;
            end else begin
                mq = 8'(ra / 16'(rb)); mr = 8'(ra % 16'(rb)); mdz = 1'b0; mov = 1'b0;
            end
            run_div(ra, rb, mq, mr, mdz, mov, (mdz || mov) ? 0 : 8, int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
